// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage buffers: control-bundle field offsets and occupancy encoding.
package pipe_pkg;

  localparam int CTRL_MEMWR  = 0;
  localparam int CTRL_MEMRD  = 1;
  localparam int CTRL_REGWR  = 2;
  localparam int CTRL_M2R_LO = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One held pipeline entry {valid, ctrl, data}; kill clears only the valid bit, data may stay stale.
module pipe_entry_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              kill,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (kill) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Reusable pipeline stage register with valid/ready handshake, flush and optional two-entry skid buffer.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 3,
  parameter int CTRL_W = 5,
  parameter int SKID   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]       in_ctrl,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [1:0]              occ
);

  localparam int DW = LANES * DATA_W;

  occ_state_t        state, state_nxt;
  logic              in_ready_r;
  logic              accept, pop;
  logic              main_load, skid_load, use_skid;
  logic              main_kill, skid_kill;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [DW-1:0]     main_data, skid_data, main_d_data;

  assign accept = in_valid & in_ready;
  assign pop    = main_valid & out_ready;

  always_comb begin
    state_nxt = state;
    main_load = 1'b0;
    skid_load = 1'b0;
    use_skid  = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          main_load = 1'b1;
          state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          main_load = 1'b1;
        end else if (accept) begin
          skid_load = 1'b1;
          state_nxt = ST_TWO;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          main_load = 1'b1;
          use_skid  = 1'b1;
          state_nxt = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // flush wins over any simultaneous accept or pop; the accepted entry is simply dropped
    if (flush) begin
      state_nxt = ST_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
      use_skid  = 1'b0;
    end
  end

  assign main_kill   = flush | (pop & ~main_load);
  assign skid_kill   = flush | use_skid;
  assign main_d_ctrl = use_skid ? skid_ctrl : in_ctrl;
  assign main_d_data = use_skid ? skid_data : in_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_EMPTY;
      in_ready_r <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_r <= (state_nxt != ST_TWO);
    end
  end

  pipe_entry_reg #(.DATA_W(DW), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .reset  (reset),
    .load   (main_load),
    .kill   (main_kill),
    .d_ctrl (main_d_ctrl),
    .d_data (main_d_data),
    .valid  (main_valid),
    .ctrl   (main_ctrl),
    .data   (main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry_reg #(.DATA_W(DW), .CTRL_W(CTRL_W)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (skid_load),
        .kill   (skid_kill),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .valid  (skid_valid),
        .ctrl   (skid_ctrl),
        .data   (skid_data)
      );
      assign in_ready = in_ready_r;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
      assign in_ready   = ~main_valid | out_ready;
    end
  endgenerate

  // bubbles never present live control, regardless of what main_ctrl still holds
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign occ       = state;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: table-driven handshake steps, in-order scoreboard, async reset and SKID=0 cases.
module tb_pipe_stage_buf;
  localparam int DATA_W = 32;
  localparam int LANES  = 3;
  localparam int CTRL_W = 5;
  localparam int DW     = DATA_W * LANES;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0]     in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [1:0]        occ;

  logic              s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
  logic [DW-1:0]     s0_in_data, s0_out_data;
  logic [CTRL_W-1:0] s0_in_ctrl, s0_out_ctrl;
  logic [1:0]        s0_occ;

  int errors = 0;
  int checks = 0;
  bit sb_en  = 1'b0;

  typedef struct packed {
    logic [DW+CTRL_W-1:0] pl;
  } sb_item_t;
  sb_item_t sbq[$];

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DATA_W), .LANES(LANES), .CTRL_W(CTRL_W), .SKID(1)) u_s1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .occ(occ)
  );

  pipe_stage_buf #(.DATA_W(DATA_W), .LANES(LANES), .CTRL_W(CTRL_W), .SKID(0)) u_s0 (
    .clk(clk), .reset(reset), .flush(s0_flush), .in_valid(s0_in_valid), .in_ready(s0_in_ready),
    .in_data(s0_in_data), .in_ctrl(s0_in_ctrl), .out_valid(s0_out_valid), .out_ready(s0_out_ready),
    .out_data(s0_out_data), .out_ctrl(s0_out_ctrl), .occ(s0_occ)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [31:0] lane0);
    mk_data = {lane0 ^ 32'h5A5A_0000, ~lane0, lane0};
  endfunction

  // scoreboard: handshakes are sampled mid-cycle and take effect at the next rising edge
  always @(negedge clk) begin
    if (sb_en) begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_pop", {out_ctrl, out_data}, '0);
        end else begin
          check("sb_pop", {out_ctrl, out_data}, sbq[0].pl);
          void'(sbq.pop_front());
        end
      end
      if (flush) sbq.delete();
      else if (in_valid && in_ready) sbq.push_back('{pl: {in_ctrl, in_data}});
    end
  end

  typedef struct {
    logic        iv, ordy, fl;
    logic [31:0] d;
    logic [4:0]  c;
    logic        e_ov;
    logic [31:0] e_d;
    logic [4:0]  e_c;
    logic [1:0]  e_occ;
    logic        e_ir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic iv, ordy, fl, input logic [31:0] d, input logic [4:0] c,
                             input logic e_ov, input logic [31:0] e_d, input logic [4:0] e_c,
                             input logic [1:0] e_occ, input logic e_ir);
    v = '{iv, ordy, fl, d, c, e_ov, e_d, e_c, e_occ, e_ir};
  endfunction

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 'x; in_ctrl = '0;
    s0_flush = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b0; s0_in_data = '0; s0_in_ctrl = '0;

    vecs.push_back(v(1, 1, 0, 32'h1234, 5'b00100, 1, 32'h1234, 5'b00100, 2'd1, 1));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(v(1, 1, 0, k, 5'b00001, 1, k, 5'b00001, 2'd1, 1));
    vecs.push_back(v(0, 1, 0, 32'h0, 5'b0, 0, 32'h0, 5'b0, 2'd0, 1));
    vecs.push_back(v(1, 0, 0, 32'hA, 5'b00010, 1, 32'hA, 5'b00010, 2'd1, 1));
    vecs.push_back(v(1, 0, 0, 32'hB, 5'b01100, 1, 32'hA, 5'b00010, 2'd2, 0));
    vecs.push_back(v(0, 0, 0, 32'h0, 5'b0, 1, 32'hA, 5'b00010, 2'd2, 0));
    vecs.push_back(v(0, 1, 0, 32'h0, 5'b0, 1, 32'hB, 5'b01100, 2'd1, 1));
    vecs.push_back(v(0, 1, 0, 32'h0, 5'b0, 0, 32'h0, 5'b0, 2'd0, 1));
    vecs.push_back(v(1, 0, 0, 32'hA, 5'b00010, 1, 32'hA, 5'b00010, 2'd1, 1));
    vecs.push_back(v(1, 0, 0, 32'hB, 5'b00100, 1, 32'hA, 5'b00010, 2'd2, 0));
    vecs.push_back(v(1, 0, 1, 32'hC, 5'b00101, 0, 32'h0, 5'b0, 2'd0, 1));
    vecs.push_back(v(0, 0, 0, 32'h0, 5'b0, 0, 32'h0, 5'b0, 2'd0, 1));
    vecs.push_back(v(1, 0, 0, 32'hD, 5'b00100, 1, 32'hD, 5'b00100, 2'd1, 1));
    vecs.push_back(v(1, 0, 1, 32'hE, 5'b00101, 0, 32'h0, 5'b0, 2'd0, 1));
    vecs.push_back(v(0, 1, 0, 32'h0, 5'b0, 0, 32'h0, 5'b0, 2'd0, 1));
    vecs.push_back(v(1, 1, 0, 32'hF, 5'b10001, 1, 32'hF, 5'b10001, 2'd1, 1));
    vecs.push_back(v(0, 1, 0, 32'h0, 5'b0, 0, 32'h0, 5'b0, 2'd0, 1));

    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_ctrl", out_ctrl, '0);
    check("rst_occ", occ, 2'd0);
    check("rst_in_ready", in_ready, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    sb_en = 1'b1;

    foreach (vecs[i]) begin
      in_valid  = vecs[i].iv;
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      in_ctrl   = vecs[i].c;
      in_data   = vecs[i].iv ? mk_data(vecs[i].d) : 'x;
      @(posedge clk); #1;
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
      check($sformatf("v%0d_out_ctrl", i), out_ctrl, vecs[i].e_c);
      check($sformatf("v%0d_occ", i), occ, vecs[i].e_occ);
      check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
      if (vecs[i].e_ov) check($sformatf("v%0d_lane0", i), out_data[31:0], vecs[i].e_d);
    end
    in_valid = 1'b0; flush = 1'b0; in_data = 'x;
    check("sb_drained", sbq.size(), 0);

    // asynchronous reset in the middle of a cycle with one live entry
    sb_en = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0; in_ctrl = 5'b00101; in_data = mk_data(32'h55);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ar_pre_ctrl", out_ctrl, 5'b00101);
    check("ar_pre_occ", occ, 2'd1);
    #2 reset = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 1'b0);
    check("ar_out_ctrl", out_ctrl, '0);
    check("ar_out_data", out_data, '0);
    check("ar_occ", occ, 2'd0);
    check("ar_in_ready", in_ready, 1'b1);
    sbq.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("ar_after_valid", out_valid, 1'b0);

    // single-entry build: combinational in_ready follows out_ready within the cycle
    s0_in_valid = 1'b1; s0_in_data = mk_data(32'h61); s0_in_ctrl = 5'b00100; s0_out_ready = 1'b0;
    check("s0_empty_ready", s0_in_ready, 1'b1);
    @(posedge clk); #1;
    check("s0_first_valid", s0_out_valid, 1'b1);
    check("s0_first_occ", s0_occ, 2'd1);
    s0_in_data = mk_data(32'h62); s0_in_ctrl = 5'b00001;
    #1;
    check("s0_stall_ready", s0_in_ready, 1'b0);
    @(posedge clk); #1;
    check("s0_stall_hold", s0_out_data, mk_data(32'h61));
    check("s0_stall_ctrl", s0_out_ctrl, 5'b00100);
    s0_out_ready = 1'b1;
    #1;
    check("s0_release_ready", s0_in_ready, 1'b1);
    @(posedge clk); #1;
    check("s0_swap_data", s0_out_data, mk_data(32'h62));
    check("s0_swap_ctrl", s0_out_ctrl, 5'b00001);
    check("s0_swap_occ", s0_occ, 2'd1);
    s0_in_valid = 1'b0;
    @(posedge clk); #1;
    check("s0_drain_valid", s0_out_valid, 1'b0);
    check("s0_drain_ctrl", s0_out_ctrl, '0);
    check("s0_drain_occ", s0_occ, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
